// File: rtl/disparity_median_filter.sv
// rtl/disparity_median_filter.sv - streaming 3x3 median post-filter for the disparity stream
// Two line buffers feed a column-sorted window; a pipelined network selects the median.
module disparity_median_filter #(
   parameter int IMG_WIDTH = 320,
   parameter int DISP_W    = 5,
   parameter int LATENCY   = 4
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic              de,
   input  logic [9:0]        x,
   input  logic [9:0]        y,
   input  logic [DISP_W-1:0] disp_in,
   input  logic              filter_en,
   output logic              de_out,
   output logic [9:0]        x_out,
   output logic [9:0]        y_out,
   output logic [DISP_W-1:0] disp_out
);
   localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

   typedef logic [DISP_W-1:0] pix_t;

   function automatic pix_t min2(input pix_t a, input pix_t b);
      return (a < b) ? a : b;
   endfunction

   function automatic pix_t max2(input pix_t a, input pix_t b);
      return (a > b) ? a : b;
   endfunction

   function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
      return min2(min2(a, b), c);
   endfunction

   function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
      return max2(max2(a, b), c);
   endfunction

   function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
      return max2(min2(a, b), min2(max2(a, b), c));
   endfunction

   pix_t lb0 [IMG_WIDTH];
   pix_t lb1 [IMG_WIDTH];
   pix_t rd0;
   pix_t rd1;
   logic [AW-1:0] addr;

   logic       p_de    [1:LATENCY-1];
   logic       p_fen   [1:LATENCY-1];
   logic       p_valid [1:LATENCY-1];
   logic [9:0] p_x     [1:LATENCY-1];
   logic [9:0] p_y     [1:LATENCY-1];
   pix_t       p_disp  [1:LATENCY-1];

   logic [1:0] lines_seen;
   logic       de_prev;
   logic       in_valid;

   pix_t w_lo  [3];
   pix_t w_mid [3];
   pix_t w_hi  [3];
   pix_t col_lo;
   pix_t col_mid;
   pix_t col_hi;
   pix_t m_lo;
   pix_t m_mid;
   pix_t m_hi;

   assign addr     = x[AW-1:0];
   assign in_valid = (x >= 10'd2) && (y >= 10'd2) && (lines_seen == 2'd2);

   // Read-before-write: lb0 moves down into lb1 as the new row lands in lb0.
   always_ff @(posedge pclk) begin
      if (de) begin
         rd0       <= lb0[addr];
         rd1       <= lb1[addr];
         lb1[addr] <= lb0[addr];
         lb0[addr] <= disp_in;
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         lines_seen <= 2'd0;
         de_prev    <= 1'b0;
      end else begin
         de_prev <= de;
         if (de_prev && !de && (lines_seen != 2'd2)) begin
            lines_seen <= lines_seen + 2'd1;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         for (int i = 1; i < LATENCY; i++) begin
            p_de[i]    <= 1'b0;
            p_fen[i]   <= 1'b0;
            p_valid[i] <= 1'b0;
            p_x[i]     <= '0;
            p_y[i]     <= '0;
            p_disp[i]  <= '0;
         end
      end else begin
         p_de[1]    <= de;
         p_fen[1]   <= filter_en;
         p_valid[1] <= in_valid;
         p_x[1]     <= x;
         p_y[1]     <= y;
         p_disp[1]  <= disp_in;
         for (int i = 2; i < LATENCY; i++) begin
            p_de[i]    <= p_de[i-1];
            p_fen[i]   <= p_fen[i-1];
            p_valid[i] <= p_valid[i-1];
            p_x[i]     <= p_x[i-1];
            p_y[i]     <= p_y[i-1];
            p_disp[i]  <= p_disp[i-1];
         end
      end
   end

   // Incoming column is rows y-2, y-1, y; it is stored already sorted.
   assign col_lo  = min3(rd1, rd0, p_disp[1]);
   assign col_mid = med3(rd1, rd0, p_disp[1]);
   assign col_hi  = max3(rd1, rd0, p_disp[1]);

   always_ff @(posedge pclk) begin
      if (p_de[1]) begin
         w_lo[0]  <= w_lo[1];
         w_lo[1]  <= w_lo[2];
         w_lo[2]  <= col_lo;
         w_mid[0] <= w_mid[1];
         w_mid[1] <= w_mid[2];
         w_mid[2] <= col_mid;
         w_hi[0]  <= w_hi[1];
         w_hi[1]  <= w_hi[2];
         w_hi[2]  <= col_hi;
      end
   end

   always_ff @(posedge pclk) begin
      m_lo  <= max3(w_lo[0], w_lo[1], w_lo[2]);
      m_mid <= med3(w_mid[0], w_mid[1], w_mid[2]);
      m_hi  <= min3(w_hi[0], w_hi[1], w_hi[2]);
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         de_out   <= 1'b0;
         x_out    <= '0;
         y_out    <= '0;
         disp_out <= '0;
      end else begin
         de_out <= p_de[LATENCY-1];
         x_out  <= p_x[LATENCY-1];
         y_out  <= p_y[LATENCY-1];
         if (!p_de[LATENCY-1]) begin
            disp_out <= '0;
         end else if (!p_fen[LATENCY-1]) begin
            disp_out <= p_disp[LATENCY-1];
         end else if (p_valid[LATENCY-1]) begin
            disp_out <= med3(m_lo, m_mid, m_hi);
         end else begin
            disp_out <= '0;
         end
      end
   end
endmodule

// File: tb/tb_disparity_median_filter.sv
// tb/tb_disparity_median_filter.sv - self-checking bench for disparity_median_filter
// Per-pixel reference model plus table-driven spot checks of the filtered image.
module tb_disparity_median_filter;
   localparam int W   = 320;
   localparam int LAT = 4;

   logic       pclk = 1'b0;
   logic       rst = 1'b1;
   logic       de = 1'b0;
   logic [9:0] x = '0;
   logic [9:0] y = '0;
   logic [4:0] disp_in = '0;
   logic       filter_en = 1'b1;
   logic       de_out;
   logic [9:0] x_out;
   logic [9:0] y_out;
   logic [4:0] disp_out;

   disparity_median_filter #(.IMG_WIDTH(W), .DISP_W(5), .LATENCY(LAT)) dut (
      .pclk(pclk), .rst(rst), .de(de), .x(x), .y(y), .disp_in(disp_in),
      .filter_en(filter_en), .de_out(de_out), .x_out(x_out), .y_out(y_out),
      .disp_out(disp_out)
   );

   always #5 pclk = ~pclk;

   typedef struct {
      int sc;
      int px;
      int py;
      int exp;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   scen = 0;
   int   rec_sel = 0;
   int   h0 [W];
   int   h1 [W];
   int   h2 [W];
   int   lines = 0;
   bit   prev_de = 1'b0;
   bit   hist_rst [8];
   bit   hist_de  [8];
   int   hist_x   [8];
   int   hist_y   [8];
   int   hist_exp [8];
   int   out_map [int];
   int   seq_a [$];
   int   seq_b [$];
   vec_t vecs [$];

   // Column c holds its last three written values: rows y, y-1, y-2.
   function automatic int window_median(input int cx);
      int v [9];
      int n = 0;
      int t;
      for (int c = cx - 2; c <= cx; c++) begin
         v[n] = h0[c];
         v[n+1] = h1[c];
         v[n+2] = h2[c];
         n += 3;
      end
      for (int i = 0; i < 9; i++)
         for (int j = 0; j < 8 - i; j++)
            if (v[j] > v[j+1]) begin
               t = v[j]; v[j] = v[j+1]; v[j+1] = t;
            end
      return v[4];
   endfunction

   function automatic int field(input int kind, input int px, input int py);
      case (kind)
         0: return 12;
         1: return (px == 100 && py == 50) ? 31 : 10;
         2: return (px == 60 && py == 40) ? 0 : 20;
         3: return (px >= 59 && px <= 61 && py >= 39 && py <= 41) ? 0 : 20;
         default: return px % 32;
      endcase
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit d, input int px, input int py, input int val, input bit fen);
      int  k;
      int  idx;
      int  e;
      int  s;
      bit  killed;
      rst = r; de = d; x = 10'(px); y = 10'(py); disp_in = 5'(val); filter_en = fen;
      k = cyc;
      idx = k % 8;
      e = 0;
      if (d) begin
         h2[px] = h1[px]; h1[px] = h0[px]; h0[px] = val;
         if (!fen) e = val;
         else if (px >= 2 && py >= 2 && lines == 2) e = window_median(px);
      end
      hist_rst[idx] = r; hist_de[idx] = d; hist_x[idx] = px; hist_y[idx] = py; hist_exp[idx] = e;
      if (r) begin
         lines = 0; prev_de = 1'b0;
      end else begin
         if (prev_de && !d && lines < 2) lines++;
         prev_de = d;
      end
      @(posedge pclk);
      #1;
      cyc = k + 1;
      killed = (k < LAT - 1);
      if (!killed)
         for (int j = k - (LAT - 1); j <= k; j++)
            if (hist_rst[j % 8]) killed = 1'b1;
      if (killed) begin
         check("de_out_flushed", de_out, 0);
         check("disp_out_flushed", disp_out, 0);
      end else begin
         s = (k - (LAT - 1)) % 8;
         check("de_out_delay", de_out, hist_de[s]);
         if (hist_de[s] && de_out) begin
            check("x_out", x_out, hist_x[s]);
            check("y_out", y_out, hist_y[s]);
            check("disp_out", disp_out, hist_exp[s]);
            out_map[scen * 1000000 + y_out * 1000 + x_out] = disp_out;
            if (rec_sel == 1 && y_out >= 49) seq_a.push_back(disp_out);
            if (rec_sel == 2 && y_out >= 49) seq_b.push_back(disp_out);
         end else if (!de_out) begin
            check("disp_out_idle", disp_out, 0);
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 0, 0, 0, 1'b1);
   endtask

   task automatic run_frame(input int kind, input int y0, input int y1, input int gaps, input bit fen);
      for (int yy = y0; yy <= y1; yy++) begin
         for (int xx = 0; xx < W; xx++) begin
            step(1'b0, 1'b1, xx, yy, field(kind, xx, yy), fen);
            idle(gaps);
         end
         idle(4);
      end
   endtask

   initial begin
      int  key;
      int  n;
      bit  fen;
      int  v;

      vecs = '{
         '{1, 0, 0, 0}, '{1, 1, 3, 0}, '{1, 2, 1, 0}, '{1, 2, 2, 12}, '{1, 319, 4, 12}, '{1, 5, 0, 0},
         '{2, 101, 51, 10}, '{2, 100, 50, 10}, '{2, 102, 52, 10}, '{2, 50, 50, 10},
         '{3, 61, 41, 20},
         '{4, 61, 41, 0}, '{4, 62, 41, 0}, '{4, 62, 42, 20}, '{4, 63, 41, 20},
         '{5, 0, 0, 0}, '{5, 1, 1, 1}, '{5, 33, 0, 1}, '{5, 31, 2, 31},
         '{6, 151, 80, 0}, '{6, 300, 80, 0}, '{6, 200, 81, 0}, '{6, 2, 82, 7},
         '{6, 160, 82, 7}, '{6, 100, 83, 7}, '{6, 1, 83, 0}
      };
      for (int i = 0; i < W; i++) begin
         h0[i] = 0; h1[i] = 0; h2[i] = 0;
      end

      repeat (3) step(1'b1, 1'b0, 0, 0, 0, 1'b1);
      idle(2);

      scen = 1; run_frame(0, 0, 4, 0, 1'b1); idle(8);
      scen = 2; rec_sel = 1; run_frame(1, 47, 53, 0, 1'b1); idle(8);
      scen = 7; rec_sel = 2; run_frame(1, 47, 53, 3, 1'b1); idle(8);
      rec_sel = 0;
      scen = 3; run_frame(2, 37, 43, 0, 1'b1); idle(8);
      scen = 4; run_frame(3, 37, 43, 0, 1'b1); idle(8);
      scen = 5; run_frame(4, 0, 3, 0, 1'b0); idle(8);

      scen = 6;
      for (int yy = 78; yy <= 84; yy++) begin
         for (int xx = 0; xx < W; xx++) begin
            v = (yy < 80 || (yy == 80 && xx < 150)) ? 10 : 7;
            step(yy == 80 && xx == 150, 1'b1, xx, yy, v, 1'b1);
         end
         idle(4);
      end
      idle(8);

      scen = 8;
      fen = 1'b1;
      for (int yy = 0; yy < 4; yy++) begin
         for (int xx = 0; xx < W; xx++) begin
            if ($urandom_range(0, 63) == 0) fen = ~fen;
            v = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31));
            step(1'b0, 1'b1, xx, yy, v, fen);
            if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(1, 3)));
         end
         idle(4);
      end
      idle(8);

      check("gap_seq_len", seq_b.size(), seq_a.size());
      n = (seq_a.size() < seq_b.size()) ? seq_a.size() : seq_b.size();
      for (int i = 0; i < n; i++) check("gap_seq", seq_b[i], seq_a[i]);

      foreach (vecs[i]) begin
         key = vecs[i].sc * 1000000 + vecs[i].py * 1000 + vecs[i].px;
         if (out_map.exists(key)) begin
            check($sformatf("table_s%0d_x%0d_y%0d", vecs[i].sc, vecs[i].px, vecs[i].py),
                  out_map[key], vecs[i].exp);
         end else begin
            check($sformatf("table_s%0d_x%0d_y%0d_present", vecs[i].sc, vecs[i].px, vecs[i].py), 0, 1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/disparity_median_filter.md
Name: disparity_median_filter

Overview:
- Streaming 3x3 median post-filter on the pixel-clock disparity stream produced by the SAD/SGM matcher.
- Removes isolated speckle and the zero holes written by the texture and uniqueness rejection, then hands the result to the display/colour-map stage.
- Works in raster order on the matcher's de/x/y timing. Uses two disparity line buffers and a pipelined sorting network.

Parameters:
- IMG_WIDTH, 320, active pixels per line; line buffer depth.
- DISP_W, 5, disparity width in bits (values 0..31, 0 = invalid).
- LATENCY, 4, fixed cycles from input pixel to output pixel.

Ports:
- pclk  input  1  pixel clock; the only clock.
- rst  input  1  synchronous active-high reset.
- de  input  1  input pixel valid (active video).
- x  input  10  input pixel column, 0..IMG_WIDTH-1.
- y  input  10  input pixel row.
- disp_in  input  DISP_W  disparity of pixel (x,y).
- filter_en  input  1  1 = median output; 0 = bypass (delayed disp_in).
- de_out  output  1  de delayed by LATENCY.
- x_out  output  10  x delayed by LATENCY.
- y_out  output  10  y delayed by LATENCY.
- disp_out  output  DISP_W  filtered disparity for (x_out,y_out).

Behaviour:
- Clocking: single clock pclk. Reset is synchronous, active-high, on rst.
- Reset values: de_out=0, x_out=0, y_out=0, disp_out=0. All pipeline valid bits cleared. lines_seen=0. Line buffer RAM is not reset.
- Line buffers: lb0 holds row y-1 and lb1 holds row y-2, each IMG_WIDTH x DISP_W.
  - On a de cycle, read lb0[x] and lb1[x], then write lb1[x]<=old lb0[x] and lb0[x]<=disp_in (read-before-write, same address).
  - No access when de=0.
- Window: three 3-entry column shift registers (rows y-2, y-1, y). They shift only on de cycles, so the window covers input columns x-2..x and is centred on (x-1,y-1).
  - The output is tagged with the input (x,y). The image is therefore shifted by one pixel right and down; this is intentional.
- lines_seen: 2-bit counter, increments on each de falling edge, saturates at 2, cleared only by rst.
- Valid window: x>=2, y>=2 and lines_seen==2. Otherwise disp_out=0 for that pixel (border/invalid, never stale RAM).
- Median:
  - Sort each column (min/mid/max).
  - Compute max of the three mins, median of the three mids, min of the three maxes.
  - Output the median of those three values.
  - Comparisons are unsigned DISP_W bits. Zeros take part as ordinary values: five or more zeros in a window yield 0.
- Bypass (filter_en=0): disp_out = disp_in of the same pixel, delayed by LATENCY. Border masking is not applied.
  - filter_en is sampled alongside the pixel on input, so a toggle affects only pixels entering after it.
- Latency: exactly LATENCY cycles for de/x/y/disp, in both modes.
  - de_out is a pure delay of de. disp_out is held at 0 when de_out=0.
- de gaps: idle cycles (de=0) inside a line freeze the window and line buffers. The result equals gap-free processing, only delayed.
- Reset mid-frame: pipeline flushes (de_out=0 for LATENCY cycles after rst deasserts). lines_seen=0 forces disp_out=0 until two full lines have completed.
- x values >= IMG_WIDTH while de=1 are a protocol error; behaviour is undefined and the bench does not exercise it.

Test Plan:
- Reset, then a constant frame disp_in=12, filter_en=1 -> disp_out=0 for y<2 or x<2; disp_out=12 for all other pixels; de_out lags de by exactly 4 cycles.
- Constant field 10 with a single pixel of 31 at (100,50) -> output at (101,51), (100,50) and all other interior pixels = 10 (impulse removed).
- Constant field 20 with one zero hole at (60,40) -> output at (61,41) = 20. A 3x3 block of zeros centred at (60,40) -> output at (61,41) = 0.
- filter_en=0, ramp disp_in = x mod 32 -> disp_out equals disp_in delayed 4 cycles, including x<2 and y<2.
- Same frame as scenario 2 but with 3 idle cycles inserted after every pixel -> disp_out sequence on de_out cycles identical to the gap-free run.
- Assert rst for 1 cycle at mid-frame pixel (150,80), then continue streaming constant 7 -> de_out=0 for 4 cycles; disp_out=0 through the end of row 81; row 82 onward interior = 7.
